ahb_master_xfer_ctrl: RTL and testbench

- AHB-Lite initiator-side transfer controller: the master-end counterpart of the slave transfer-response logic (HREADY/HRESP generation).
- Accepts single-word read/write requests from a local client over a valid/ready interface.
- Sequences the AHB address and data phases, and waits on HREADY.
- Interprets OKAY and two-cycle ERROR responses, plus a wait-state timeout, and returns one response per request to the client.
- One outstanding transfer at a time; NONSEQ only; no bursts.

---
 rtl/ahb_master_xfer_ctrl.sv | 146 ++++++++++++++
 tb/tb_ahb_master_xfer_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ahb_master_xfer_ctrl.sv
// ahb_master_xfer_ctrl: AHB-Lite initiator that runs one single-word NONSEQ transfer per client request.
//   Client side : req_valid/req_ready/req_write/req_addr/req_wdata in, rsp_valid/rsp_error/rsp_timeout/rsp_rdata out.
//   AHB side    : HADDR/HTRANS/HWRITE/HSIZE/HWDATA out, HRDATA/HREADY/HRESP in.
//   HCLK rising edge, HRESETn synchronous active-low.
module ahb_master_xfer_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;
    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LIM_M1 = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              wait_edge, timeout;

    assign wait_edge = (state_q == S_ADDR || state_q == S_DATA) && !HREADY;
    // The edge that would make the count reach the limit fires the timeout.
    assign timeout   = (WAIT_LIMIT != 0) && wait_edge && (cnt_q == LIM_M1);

    always_comb begin
        state_d       = state_q;
        haddr_d       = haddr_q;
        htrans_d      = htrans_q;
        hwrite_d      = hwrite_q;
        hwdata_d      = hwdata_q;
        wdata_d       = wdata_q;
        cnt_d         = (wait_edge && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_error_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
        if (timeout) begin
            state_d       = S_IDLE;
            htrans_d      = 2'b00;
            hwdata_d      = '0;
            rsp_valid_d   = 1'b1;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    state_d  = S_ADDR;
                    htrans_d = 2'b10;
                    haddr_d  = req_addr;
                    hwrite_d = req_write;
                    wdata_d  = req_wdata;
                    cnt_d    = '0;
                end
                S_ADDR: if (HREADY) begin
                    state_d  = S_DATA;
                    htrans_d = 2'b00;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                end
                S_DATA: if (HREADY) begin
                    // HRESP with HREADY and no first ERROR cycle is a protocol violation, reported as error.
                    state_d     = S_IDLE;
                    hwdata_d    = '0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = HRESP;
                    rsp_rdata_d = (!HRESP && !hwrite_q) ? HRDATA : '0;
                end else if (HRESP) begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d     = S_IDLE;
                    hwdata_d    = '0;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q       <= S_IDLE;
            haddr_q       <= '0;
            htrans_q      <= 2'b00;
            hwrite_q      <= 1'b0;
            hwdata_q      <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            haddr_q       <= haddr_d;
            htrans_q      <= htrans_d;
            hwrite_q      <= hwrite_d;
            hwdata_q      <= hwdata_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    assign req_ready   = HRESETn && (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HWRITE      = hwrite_q;
    assign HSIZE       = 3'b010;
    assign HWDATA      = hwdata_q;
endmodule

// File: tb/tb_ahb_master_xfer_ctrl.sv
// tb_ahb_master_xfer_ctrl: directed bench for ahb_master_xfer_ctrl with a response scoreboard.
module tb_ahb_master_xfer_ctrl;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [33:0] exp_q[$];

    ahb_master_xfer_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_LIMIT(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response pulse must match the oldest pending expectation.
    always @(negedge HCLK) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) check("unexpected_rsp", 34'(rsp_valid), 34'(0));
            else check("rsp", {rsp_error, rsp_timeout, rsp_rdata}, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Runs one transfer; rdy/resp bit c is the slave's HREADY/HRESP during cycle c (cycle 0 = accept).
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [15:0] rdy, input logic [15:0] resp, input logic [31:0] rdata,
                        input int exp_cyc, input logic e_err, input logic e_to, input logic [31:0] e_rdata);
        bit in_addr = 1'b1;
        bit data_ph = 1'b0;
        exp_q.push_back({e_err, e_to, e_rdata});
        req_valid = 1'b1; req_write = we; req_addr = addr; req_wdata = wdata;
        HREADY = 1'b1; HRESP = 1'b0;
        check("req_ready_idle", 34'(req_ready), 34'(1));
        for (int c = 0; c < exp_cyc; c++) begin
            if (c > 0) begin HREADY = rdy[c]; HRESP = resp[c]; HRDATA = rdata; end
            step();
            req_valid = 1'b0;
            if (c > 0 && in_addr && rdy[c]) begin in_addr = 1'b0; data_ph = 1'b1; end
            if (c == 0) begin
                check("haddr", 34'(HADDR), 34'(addr));
                check("hwrite", 34'(HWRITE), 34'(we));
                check("hsize", 34'(HSIZE), 34'(3'b010));
            end
            check("rsp_valid_timing", 34'(rsp_valid), 34'(c + 1 == exp_cyc));
            check("req_ready_busy", 34'(req_ready), 34'(c + 1 == exp_cyc));
            check("htrans", 34'(HTRANS), (in_addr && c + 1 < exp_cyc) ? 34'(2) : 34'(0));
            check("hwdata", 34'(HWDATA), (we && data_ph && c + 1 < exp_cyc) ? 34'(wdata) : 34'(0));
        end
        HREADY = 1'b1; HRESP = 1'b0;
    endtask

    initial begin
        step();
        step();
        check("rst_htrans", 34'(HTRANS), 34'(0));
        check("rst_rsp_valid", 34'(rsp_valid), 34'(0));
        check("rst_req_ready", 34'(req_ready), 34'(0));
        check("rst_haddr", 34'(HADDR), 34'(0));
        check("rst_hwdata", 34'(HWDATA), 34'(0));
        HRESETn = 1'b1;
        #1;
        check("rel_req_ready", 34'(req_ready), 34'(1));

        // zero-wait write
        xfer(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 16'hFFFF, 16'h0000, 32'h0, 3, 1'b0, 1'b0, 32'h0);
        // read with 3 data-phase wait states
        xfer(1'b0, 32'h0000_0080, 32'h0, 16'b10_0011, 16'h0000, 32'h1234_5678, 6, 1'b0, 1'b0, 32'h1234_5678);
        // write with 2 address-phase and 1 data-phase wait
        xfer(1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 16'b10_1001, 16'h0000, 32'h0, 6, 1'b0, 1'b0, 32'h0);
        // two-cycle ERROR on a read: rdata must be 0
        xfer(1'b0, 32'h0000_0104, 32'h0, 16'b1011, 16'b1100, 32'hAAAA_AAAA, 4, 1'b1, 1'b0, 32'h0);
        // protocol violation: HREADY=1/HRESP=1 without a first ERROR cycle
        xfer(1'b0, 32'h0000_0108, 32'h0, 16'b111, 16'b100, 32'h5555_5555, 3, 1'b1, 1'b0, 32'h0);
        // timeout in address phase, HREADY stuck low
        xfer(1'b0, 32'h0000_0200, 32'h0, 16'h0001, 16'h0000, 32'h0, 5, 1'b1, 1'b1, 32'h0);
        // back-to-back follow-up accepted in the response cycle
        xfer(1'b0, 32'h0000_0204, 32'h0, 16'hFFFF, 16'h0000, 32'h0F0F_0F0F, 3, 1'b0, 1'b0, 32'h0F0F_0F0F);
        // timeout in data phase wins over a first ERROR cycle on the same edge
        xfer(1'b1, 32'h0000_0208, 32'h1111_2222, 16'b00_0011, 16'b10_0000, 32'h0, 6, 1'b1, 1'b1, 32'h0);

        // reset asserted in the data phase abandons the transfer
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0300; req_wdata = 32'hCAFE_F00D;
        step();
        req_valid = 1'b0;
        step();
        check("pre_rst_hwdata", 34'(HWDATA), 34'(32'hCAFE_F00D));
        HREADY = 1'b0;
        HRESETn = 1'b0;
        step();
        check("midrst_htrans", 34'(HTRANS), 34'(0));
        check("midrst_hwdata", 34'(HWDATA), 34'(0));
        check("midrst_rsp_valid", 34'(rsp_valid), 34'(0));
        check("midrst_req_ready", 34'(req_ready), 34'(0));
        HRESETn = 1'b1;
        HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_rsp", 34'(rsp_valid), 34'(0));
        end
        xfer(1'b0, 32'h0000_0304, 32'h0, 16'hFFFF, 16'h0000, 32'h0BAD_F00D, 3, 1'b0, 1'b0, 32'h0BAD_F00D);

        step();
        step();
        check("pending_rsps", 34'(exp_q.size()), 34'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
